// File: rtl/raster_sync_gen.sv
// Raster timing generator: dot/line counters, hsync/vsync with interlace phase,
// and a timing configuration that is validated and latched only at field wrap.
module raster_sync_gen #(
   parameter int HBITS           = 12,
   parameter int VBITS           = 10,
   parameter int DEF_HTOTAL      = 2015,
   parameter int DEF_HSYNC_LEN   = 152,
   parameter int DEF_VTOTAL      = 311,
   parameter int DEF_VSYNC_START = 300,
   parameter int DEF_VSYNC_LINES = 3
) (
   input  logic             clk32,
   input  logic             reset,
   input  logic             pause,
   input  logic [HBITS-1:0] htotal,
   input  logic [HBITS-1:0] hsync_len,
   input  logic [VBITS-1:0] vtotal,
   input  logic [VBITS-1:0] vsync_start,
   input  logic [3:0]       vsync_lines,
   input  logic             interlace,
   output logic             hsync,
   output logic             vsync,
   output logic             field,
   output logic [HBITS-1:0] dot,
   output logic [VBITS-1:0] line,
   output logic             sof,
   output logic             cfg_err
);

   logic [HBITS-1:0] dot_q, dot_d;
   logic [VBITS-1:0] line_q, line_d;
   logic             field_q, field_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             sof_q;
   logic             cfgErr_q, cfgErr_d;

   logic [HBITS-1:0] aHtotal_q, aHtotal_d;
   logic [HBITS-1:0] aHsyncLen_q, aHsyncLen_d;
   logic [VBITS-1:0] aVtotal_q, aVtotal_d;
   logic [VBITS-1:0] aVsyncStart_q, aVsyncStart_d;
   logic [3:0]       aVsyncLines_q, aVsyncLines_d;
   logic             aInterlace_q, aInterlace_d;

   logic             lastDot, lastLine, fieldWrap, cfgValid;
   logic [HBITS:0]   halfExt, vsOffset, dotExt;
   logic [VBITS:0]   lineExt, vsStartExt, vsEnd;
   logic             vsAfterStart, vsBeforeEnd;

   // Outputs are derived from the next position and next configuration so
   // every registered output agrees with the dot/line shown in the same cycle.
   always_comb begin
      lastDot   = (dot_q == aHtotal_q);
      lastLine  = ({1'b0, line_q} == ({1'b0, aVtotal_q} + (VBITS+1)'(field_q)));
      fieldWrap = lastDot && lastLine;
      cfgValid  = (htotal >= HBITS'(255)) && (vtotal >= VBITS'(15)) &&
                  (hsync_len <= htotal) && (vsync_lines != 4'd0) &&
                  (({1'b0, vsync_start} + (VBITS+1)'(vsync_lines)) <= {1'b0, vtotal});

      aHtotal_d     = aHtotal_q;
      aHsyncLen_d   = aHsyncLen_q;
      aVtotal_d     = aVtotal_q;
      aVsyncStart_d = aVsyncStart_q;
      aVsyncLines_d = aVsyncLines_q;
      aInterlace_d  = aInterlace_q;
      cfgErr_d      = cfgErr_q;
      field_d       = field_q;
      dot_d         = dot_q + HBITS'(1);
      line_d        = line_q;

      if (lastDot) begin
         dot_d  = '0;
         line_d = line_q + VBITS'(1);
      end

      if (fieldWrap) begin
         line_d = '0;
         if (cfgValid) begin
            aHtotal_d     = htotal;
            aHsyncLen_d   = hsync_len;
            aVtotal_d     = vtotal;
            aVsyncStart_d = vsync_start;
            aVsyncLines_d = vsync_lines;
            aInterlace_d  = interlace;
            cfgErr_d      = 1'b0;
            field_d       = interlace ? ~field_q : 1'b0;
         end else begin
            cfgErr_d = 1'b1;
            field_d  = aInterlace_q ? ~field_q : field_q;
         end
      end

      hsync_d = (dot_d < aHsyncLen_d);

      // Field 1 shifts the vsync window by half a line to signal interlace.
      halfExt      = ({1'b0, aHtotal_d} + (HBITS+1)'(1)) >> 1;
      vsOffset     = field_d ? halfExt : '0;
      dotExt       = {1'b0, dot_d};
      lineExt      = {1'b0, line_d};
      vsStartExt   = {1'b0, aVsyncStart_d};
      vsEnd        = vsStartExt + (VBITS+1)'(aVsyncLines_d);
      vsAfterStart = (lineExt > vsStartExt) || ((lineExt == vsStartExt) && (dotExt >= vsOffset));
      vsBeforeEnd  = (lineExt < vsEnd) || ((lineExt == vsEnd) && (dotExt < vsOffset));
      vsync_d      = vsAfterStart && vsBeforeEnd;
   end

   // Pause freezes everything; only the start-of-field pulse is dropped.
   always_ff @(posedge clk32 or posedge reset) begin
      if (reset) begin
         dot_q         <= '0;
         line_q        <= '0;
         field_q       <= 1'b0;
         hsync_q       <= (DEF_HSYNC_LEN != 0);
         vsync_q       <= 1'b0;
         sof_q         <= 1'b0;
         cfgErr_q      <= 1'b0;
         aHtotal_q     <= HBITS'(DEF_HTOTAL);
         aHsyncLen_q   <= HBITS'(DEF_HSYNC_LEN);
         aVtotal_q     <= VBITS'(DEF_VTOTAL);
         aVsyncStart_q <= VBITS'(DEF_VSYNC_START);
         aVsyncLines_q <= 4'(DEF_VSYNC_LINES);
         aInterlace_q  <= 1'b0;
      end else if (pause) begin
         sof_q <= 1'b0;
      end else begin
         dot_q         <= dot_d;
         line_q        <= line_d;
         field_q       <= field_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         sof_q         <= fieldWrap;
         cfgErr_q      <= cfgErr_d;
         aHtotal_q     <= aHtotal_d;
         aHsyncLen_q   <= aHsyncLen_d;
         aVtotal_q     <= aVtotal_d;
         aVsyncStart_q <= aVsyncStart_d;
         aVsyncLines_q <= aVsyncLines_d;
         aInterlace_q  <= aInterlace_d;
      end
   end

   assign hsync   = hsync_q;
   assign vsync   = vsync_q;
   assign field   = field_q;
   assign dot     = dot_q;
   assign line    = line_q;
   assign sof     = sof_q;
   assign cfg_err = cfgErr_q;

endmodule

// File: tb/tb_raster_sync_gen.sv
// Directed bench for raster_sync_gen: a small-raster instance exercises field
// timing, interlace, config validation, pause and reset; a PAL-default one checks line timing.
module tb_raster_sync_gen;

   logic        clk32;
   logic        reset;
   logic        pause;
   logic [11:0] htotal;
   logic [11:0] hsyncLen;
   logic [9:0]  vtotal;
   logic [9:0]  vsyncStart;
   logic [3:0]  vsyncLines;
   logic        interlace;

   logic        hsync, vsync, field, sof, cfgErr;
   logic [11:0] dot;
   logic [9:0]  line;
   logic        palHsync, palVsync, palField, palSof, palCfgErr;
   logic [11:0] palDot;
   logic [9:0]  palLine;

   int compareCount = 0;
   int failCount    = 0;
   int cyc          = 0;

   // Small raster: 300 dots x 20 lines so full fields fit in a short run.
   raster_sync_gen #(
      .HBITS(12), .VBITS(10),
      .DEF_HTOTAL(299), .DEF_HSYNC_LEN(20), .DEF_VTOTAL(19),
      .DEF_VSYNC_START(15), .DEF_VSYNC_LINES(3)
   ) dut (
      .clk32(clk32), .reset(reset), .pause(pause),
      .htotal(htotal), .hsync_len(hsyncLen), .vtotal(vtotal),
      .vsync_start(vsyncStart), .vsync_lines(vsyncLines), .interlace(interlace),
      .hsync(hsync), .vsync(vsync), .field(field), .dot(dot), .line(line),
      .sof(sof), .cfg_err(cfgErr)
   );

   raster_sync_gen pal (
      .clk32(clk32), .reset(reset), .pause(pause),
      .htotal(htotal), .hsync_len(hsyncLen), .vtotal(vtotal),
      .vsync_start(vsyncStart), .vsync_lines(vsyncLines), .interlace(interlace),
      .hsync(palHsync), .vsync(palVsync), .field(palField), .dot(palDot), .line(palLine),
      .sof(palSof), .cfg_err(palCfgErr)
   );

   initial clk32 = 1'b0;
   always #5 clk32 = ~clk32;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int ht, input int hl, input int vt, input int vs,
                                input int vl, input logic il);
      htotal     = 12'(ht);
      hsyncLen   = 12'(hl);
      vtotal     = 10'(vt);
      vsyncStart = 10'(vs);
      vsyncLines = 4'(vl);
      interlace  = il;
   endtask

   task automatic goTo(input int target);
      while (cyc < target) begin
         @(posedge clk32);
         #1;
         cyc++;
      end
   endtask

   task automatic holdPause(input int n);
      pause = 1'b1;
      repeat (n) @(posedge clk32);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      pause = 1'b0;
      applyStimulus(299, 20, 19, 15, 3, 1'b0);
      repeat (2) @(posedge clk32);
      #1;
      checkOutput("rst_dot", 32'(dot), 0);
      checkOutput("rst_line", 32'(line), 0);
      checkOutput("rst_hsync", 32'(hsync), 1);
      checkOutput("rst_vsync", 32'(vsync), 0);
      checkOutput("rst_field", 32'(field), 0);
      checkOutput("rst_sof", 32'(sof), 0);
      checkOutput("rst_cfgerr", 32'(cfgErr), 0);
      checkOutput("pal_rst_hsync", 32'(palHsync), 1);
      reset = 1'b0;
      cyc   = 0;

      goTo(1);     checkOutput("first_dot", 32'(dot), 1);
                   checkOutput("first_sof", 32'(sof), 0);
      goTo(19);    checkOutput("hs_last_high", 32'(hsync), 1);
      goTo(20);    checkOutput("hs_first_low", 32'(hsync), 0);
      goTo(151);   checkOutput("pal_hs_high", 32'(palHsync), 1);
      goTo(152);   checkOutput("pal_hs_low", 32'(palHsync), 0);
      goTo(299);   checkOutput("line_end_dot", 32'(dot), 299);
      goTo(300);   checkOutput("wrap_dot", 32'(dot), 0);
                   checkOutput("wrap_line", 32'(line), 1);
                   checkOutput("wrap_hsync", 32'(hsync), 1);

      // Interlaced 256x16 config programmed mid-field; must wait for the wrap.
      goTo(1000);  applyStimulus(255, 16, 15, 10, 2, 1'b1);
      goTo(2015);  checkOutput("pal_end_dot", 32'(palDot), 2015);
      goTo(2016);  checkOutput("pal_wrap_dot", 32'(palDot), 0);
                   checkOutput("pal_wrap_line", 32'(palLine), 1);
                   checkOutput("pal_wrap_hsync", 32'(palHsync), 1);
      goTo(3000);  checkOutput("pal_no_vsync", 32'(palVsync), 0);
      goTo(4499);  checkOutput("vs0_before", 32'(vsync), 0);
      goTo(4500);  checkOutput("vs0_rise", 32'(vsync), 1);
      goTo(5399);  checkOutput("vs0_last", 32'(vsync), 1);
      goTo(5400);  checkOutput("vs0_fall", 32'(vsync), 0);
      goTo(5999);  checkOutput("old_timing_dot", 32'(dot), 299);
                   checkOutput("old_timing_line", 32'(line), 19);
                   checkOutput("pre_wrap_sof", 32'(sof), 0);
      goTo(6000);  checkOutput("fw1_sof", 32'(sof), 1);
                   checkOutput("fw1_dot", 32'(dot), 0);
                   checkOutput("fw1_line", 32'(line), 0);
                   checkOutput("fw1_field", 32'(field), 1);
                   checkOutput("fw1_cfgerr", 32'(cfgErr), 0);
      goTo(6001);  checkOutput("sof_one_cycle", 32'(sof), 0);
      goTo(6255);  checkOutput("new_end_dot", 32'(dot), 255);
      goTo(6256);  checkOutput("new_wrap_dot", 32'(dot), 0);
                   checkOutput("new_wrap_line", 32'(line), 1);
      goTo(8687);  checkOutput("vs1_before", 32'(vsync), 0);
      goTo(8688);  checkOutput("vs1_rise", 32'(vsync), 1);
                   checkOutput("vs1_hsync", 32'(hsync), 0);
                   checkOutput("vs1_dot", 32'(dot), 128);
                   checkOutput("vs1_line", 32'(line), 10);
      goTo(9199);  checkOutput("vs1_last", 32'(vsync), 1);
      goTo(9200);  checkOutput("vs1_fall", 32'(vsync), 0);
      goTo(10351); checkOutput("f1_last_line", 32'(line), 16);
                   checkOutput("f1_last_dot", 32'(dot), 255);
      goTo(10352); checkOutput("fw2_sof", 32'(sof), 1);
                   checkOutput("fw2_field", 32'(field), 0);

      goTo(12000); applyStimulus(10, 16, 15, 10, 2, 1'b1);
      goTo(12911); checkOutput("vs2_before", 32'(vsync), 0);
      goTo(12912); checkOutput("vs2_rise", 32'(vsync), 1);
                   checkOutput("vs2_hsync", 32'(hsync), 1);
                   checkOutput("vs2_dot", 32'(dot), 0);
      goTo(14447); checkOutput("f0_last_line", 32'(line), 15);
                   checkOutput("f0_last_field", 32'(field), 0);
      goTo(14448); checkOutput("bad_sof", 32'(sof), 1);
                   checkOutput("bad_cfgerr", 32'(cfgErr), 1);
                   checkOutput("bad_field", 32'(field), 1);
      goTo(14703); checkOutput("bad_keep_dot", 32'(dot), 255);
      goTo(14704); checkOutput("bad_keep_wrap", 32'(dot), 0);
                   checkOutput("bad_keep_line", 32'(line), 1);

      goTo(15000); applyStimulus(255, 16, 15, 10, 2, 1'b0);
      goTo(18799); checkOutput("err_held", 32'(cfgErr), 1);
                   checkOutput("f1b_last_line", 32'(line), 16);
      goTo(18800); checkOutput("fix_sof", 32'(sof), 1);
                   checkOutput("fix_cfgerr", 32'(cfgErr), 0);
                   checkOutput("fix_field", 32'(field), 0);

      holdPause(3);
      checkOutput("pause_sof", 32'(sof), 0);
      checkOutput("pause_dot", 32'(dot), 0);
      checkOutput("pause_line", 32'(line), 0);
      pause = 1'b0;
      goTo(18801); checkOutput("resume_dot", 32'(dot), 1);

      goTo(21359); checkOutput("vs3_before", 32'(vsync), 0);
      goTo(21360); checkOutput("vs3_rise", 32'(vsync), 1);
      goTo(21400);
      holdPause(500);
      checkOutput("vpause_dot", 32'(dot), 40);
      checkOutput("vpause_line", 32'(line), 10);
      checkOutput("vpause_vsync", 32'(vsync), 1);
      checkOutput("vpause_sof", 32'(sof), 0);
      pause = 1'b0;
      goTo(21401); checkOutput("vresume_dot", 32'(dot), 41);
      goTo(21410); checkOutput("pre_rst_hsync", 32'(hsync), 0);
                   checkOutput("pre_rst_dot", 32'(dot), 50);

      // Reset lands between edges; outputs must clear without a clock.
      #2;
      reset = 1'b1;
      #1;
      checkOutput("arst_hsync", 32'(hsync), 1);
      checkOutput("arst_vsync", 32'(vsync), 0);
      checkOutput("arst_dot", 32'(dot), 0);
      checkOutput("arst_line", 32'(line), 0);
      checkOutput("arst_pal_dot", 32'(palDot), 0);
      #2;
      reset = 1'b0;
      @(posedge clk32);
      #1;
      checkOutput("restart_dot", 32'(dot), 1);
      checkOutput("restart_line", 32'(line), 0);
      checkOutput("restart_field", 32'(field), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
